// File: rtl/tt_sweep.sv
// Sweeps checker inputs 0..LAST (SETTLE clocks each) and captures R into a truth table plus ones count.
// Latency: done pulses the cycle after edge (LAST+1)*SETTLE from start; no backpressure, start ignored unless idle.
module tt_sweep #(
    parameter int SETTLE = 2,
    parameter int LAST   = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        r,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  ones
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    localparam logic [7:0] SAMPLE_CNT = 8'(SETTLE - 1);
    localparam logic [3:0] LAST_IDX   = 4'(LAST);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [3:0]  vec;
    logic [7:0]  cnt;
    logic        sample;
    logic        last_vec;

    assign sample   = (state == SWEEP) && (cnt == SAMPLE_CNT);
    assign last_vec = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SWEEP;
            SWEEP:   if (sample && last_vec) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // vec is a separate register so a..d only move on the sampling edge and read 0 outside SWEEP
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx         <= '0;
            vec         <= '0;
            cnt         <= '0;
            truth_table <= '0;
            ones        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx         <= '0;
                        vec         <= '0;
                        cnt         <= '0;
                        truth_table <= '0;
                        ones        <= '0;
                    end
                end
                SWEEP: begin
                    cnt <= cnt + 8'd1;
                    if (sample) begin
                        truth_table[idx] <= r;
                        ones             <= ones + {4'b0000, r};
                        cnt              <= '0;
                        if (last_vec) begin
                            vec <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                            vec <= idx + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign {a, b, c, d} = vec;
    assign busy         = (state == SWEEP);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_tt_sweep.sv
// Directed bench for tt_sweep: default instance plus a SETTLE=1, LAST=3 instance.
module tb_tt_sweep;

    logic clk;
    logic rstn;
    logic start;
    int   sel;
    int   mode;
    int   total;
    int   bad;

    logic        a0, b0, c0, d0, busy0, done0, r0;
    logic [15:0] tt0;
    logic [4:0]  ones0;
    logic        a1, b1, c1, d1, busy1, done1, r1;
    logic [15:0] tt1;
    logic [4:0]  ones1;

    logic [3:0]  v0, v1, vec_o;
    logic        busy_o, done_o;
    logic [15:0] tt_o;
    logic [4:0]  ones_o;

    function automatic logic rfun(input int m, input logic [3:0] v);
        case (m)
            0:       return v[3];
            1:       return v[0];
            2:       return 1'b1;
            3:       return (v[3] & v[2]) | (~v[1] & v[0]);
            5:       return v[1];
            default: return 1'b0;
        endcase
    endfunction

    assign v0 = {a0, b0, c0, d0};
    assign v1 = {a1, b1, c1, d1};
    assign r0 = rfun(mode, v0);
    assign r1 = rfun(mode, v1);

    assign vec_o  = (sel == 1) ? v1    : v0;
    assign busy_o = (sel == 1) ? busy1 : busy0;
    assign done_o = (sel == 1) ? done1 : done0;
    assign tt_o   = (sel == 1) ? tt1   : tt0;
    assign ones_o = (sel == 1) ? ones1 : ones0;

    tt_sweep dut0 (
        .clk(clk), .rstn(rstn), .start(start && sel == 0), .r(r0),
        .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
        .truth_table(tt0), .ones(ones0)
    );

    tt_sweep #(.SETTLE(1), .LAST(3)) dut1 (
        .clk(clk), .rstn(rstn), .start(start && sel == 1), .r(r1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .truth_table(tt1), .ones(ones1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          inst;
        int          mode;
        bit          poke;
        logic [15:0] exp_tt;
        logic [4:0]  exp_ones;
    } vec_t;

    task automatic run_sweep(input int inst, input int m, input bit poke,
                             input logic [15:0] exp_tt, input logic [4:0] exp_ones);
        int settle;
        int last;
        int done_edge;
        settle    = (inst == 1) ? 1 : 2;
        last      = (inst == 1) ? 3 : 15;
        done_edge = -1;
        sel       = inst;
        mode      = m;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        for (int e = 0; e <= 200 && done_edge < 0; e++) begin
            if (e > 0) tick();
            if (poke && e == 7) start = 1'b1;
            if (poke && e == 8) start = 1'b0;
            if (done_o) begin
                done_edge = e;
            end else begin
                chk($sformatf("busy_e%0d", e), int'(busy_o), 1);
                chk($sformatf("vec_e%0d", e), int'(vec_o), e / settle);
            end
        end
        chk("done_edge", done_edge, (last + 1) * settle);
        if (done_edge >= 0) begin
            chk("busy_at_done", int'(busy_o), 0);
            chk("vec_at_done", int'(vec_o), 0);
            chk("table", int'(tt_o), int'(exp_tt));
            chk("ones", int'(ones_o), int'(exp_ones));
            if (poke) start = 1'b1;
            tick();
            start = 1'b0;
            chk("done_single", int'(done_o), 0);
            chk("idle_busy", int'(busy_o), 0);
            chk("table_hold", int'(tt_o), int'(exp_tt));
        end
    endtask

    task automatic wait_done(output int edges);
        edges = -1;
        for (int e = 0; e <= 200 && edges < 0; e++) begin
            tick();
            if (done_o) edges = e + 1;
        end
    endtask

    vec_t vt [6];
    int   n;

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        start = 1'b0;
        sel   = 0;
        mode  = 0;

        vt[0] = '{0, 0, 1'b0, 16'hFF00, 5'd8};
        vt[1] = '{0, 1, 1'b1, 16'hAAAA, 5'd8};
        vt[2] = '{0, 2, 1'b0, 16'hFFFF, 5'd16};
        vt[3] = '{0, 3, 1'b0, 16'hF222, 5'd7};
        vt[4] = '{1, 1, 1'b0, 16'h000A, 5'd2};
        vt[5] = '{1, 5, 1'b0, 16'h000C, 5'd2};

        #2;
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_vec", int'(v0), 0);
        chk("rst_table", int'(tt0), 0);
        chk("rst_ones", int'(ones0), 0);
        tick();
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_sweep(vt[i].inst, vt[i].mode, vt[i].poke, vt[i].exp_tt, vt[i].exp_ones);
            tick();
        end

        // start held high: back-to-back sweeps with one idle cycle between
        sel   = 0;
        mode  = 4;
        start = 1'b1;
        wait_done(n);
        chk("held_first_done", n, 33);
        tick();
        chk("held_gap_busy", int'(busy_o), 0);
        chk("held_gap_done", int'(done_o), 0);
        tick();
        chk("held_restart_busy", int'(busy_o), 1);
        wait_done(n);
        chk("held_second_done", n, 32);
        chk("held_table", int'(tt_o), 0);
        chk("held_ones", int'(ones_o), 0);
        start = 1'b0;
        tick();
        tick();

        // reset mid-sweep with r tied high so the partial table is nonzero
        mode  = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("mid_partial", int'(tt_o), 16'h001F);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_done", int'(done_o), 0);
        chk("mid_rst_table", int'(tt_o), 0);
        chk("mid_rst_ones", int'(ones_o), 0);
        chk("mid_rst_vec", int'(vec_o), 0);
        #2;
        rstn = 1'b1;
        tick();
        chk("post_rst_done", int'(done_o), 0);
        run_sweep(0, 0, 1'b0, 16'hFF00, 5'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
